// File: rtl/load_store_unit_if.sv
// Single-port data-memory interface between the load/store unit (master) and
// the byte-addressed data cache (slave); read data returns one cycle after issue.
interface MemoryInterfaceSinglePort #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) ();
  logic                     enable;
  logic                     write_enable;
  logic [3:0]               byte_enable;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0]    write_data;
  logic [DATA_WIDTH-1:0]    read_data;

  modport master (
    output enable, write_enable, byte_enable, address, write_data,
    input  read_data
  );

  modport slave (
    input  enable, write_enable, byte_enable, address, write_data,
    output read_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts one RV32 load/store, range-checks it,
// issues a single cache access and returns an extended, held response.
module load_store_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_is_store,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_store_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic                     resp_fault,
  MemoryInterfaceSinglePort.master mem
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic [ADDRESS_WIDTH:0] LAST_BYTE = (ADDRESS_WIDTH+1)'(DEPTH*4-1);

  state_t     state;
  logic       is_store_q;
  logic [2:0] funct3_q;

  logic [ADDRESS_WIDTH:0] size_m1;
  logic [ADDRESS_WIDTH:0] end_byte;
  logic [3:0]             byte_en;
  logic                   funct3_ok;
  logic                   legal;
  logic [DATA_WIDTH-1:0]  load_ext;

  // Decode of the incoming request; the extra top bit makes address wrap-around
  // land above the legal range instead of aliasing to a low address.
  always_comb begin
    size_m1 = '0;
    byte_en = 4'b1111;
    case (req_funct3[1:0])
      2'b00:   begin size_m1 = (ADDRESS_WIDTH+1)'(0); byte_en = 4'b0001; end
      2'b01:   begin size_m1 = (ADDRESS_WIDTH+1)'(1); byte_en = 4'b0011; end
      default: begin size_m1 = (ADDRESS_WIDTH+1)'(3); byte_en = 4'b1111; end
    endcase
    if (req_is_store)
      funct3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else
      funct3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end_byte = {1'b0, req_address} + size_m1;
    legal    = funct3_ok && (end_byte <= LAST_BYTE);
  end

  always_comb begin
    load_ext = mem.read_data;
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){mem.read_data[7]}}, mem.read_data[7:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, mem.read_data[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){mem.read_data[15]}}, mem.read_data[15:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, mem.read_data[15:0]};
      default: load_ext = mem.read_data;
    endcase
  end

  // NOTE: every register here, including the memory strobes, uses non-blocking
  // assignment and is cleared by the async reset so an abandoned access drops at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      resp_fault       <= 1'b0;
      is_store_q       <= 1'b0;
      funct3_q         <= '0;
      mem.enable       <= 1'b0;
      mem.write_enable <= 1'b0;
      mem.byte_enable  <= '0;
      mem.address      <= '0;
      mem.write_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            resp_data  <= '0;
            if (legal) begin
              state            <= ISSUE;
              resp_fault       <= 1'b0;
              mem.enable       <= 1'b1;
              mem.write_enable <= req_is_store;
              mem.byte_enable  <= byte_en;
              mem.address      <= req_address;
              mem.write_data   <= req_store_data;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end
          end
        end
        ISSUE: begin
          mem.enable       <= 1'b0;
          mem.write_enable <= 1'b0;
          if (is_store_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          resp_data  <= load_ext;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Master-side driver for the `MemoryInterfaceSinglePort` data-memory port in the memory pipeline stage. It accepts one RV32 load/store request at a time from the execute stage and drives the data cache. The cache is byte-addressed, and read data appears one cycle after the read is issued. The unit range-checks the request, builds byte enables, issues exactly one memory access, and sign- or zero-extends load results. It returns a held response to the writeback stage using a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32: data bus width; only 32 is supported.
- `ADDRESS_WIDTH`, 32: request/memory byte-address width.
- `DEPTH`, 16: cache depth in words; the legal byte range is 0 to DEPTH*4-1.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; asserted only in IDLE.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 size/sign code.
- `req_address`  in  ADDRESS_WIDTH  byte address.
- `req_store_data`  in  DATA_WIDTH  store data, with the byte to write in [7:0] for byte stores.
- `resp_valid`  out  1  response held until accepted.
- `resp_ready`  in  1  writeback accepts the response.
- `resp_data`  out  DATA_WIDTH  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  access fault: out-of-range address or illegal funct3.
- `mem`  MemoryInterfaceSinglePort.master  drives `enable`, `write_enable`, `byte_enable[3:0]`, `address`, `write_data`; samples `read_data`.

## Operation
- The FSM has four states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - `req_ready`=1.
  - When `req_valid` is high, the request is registered (address, store flag, funct3, data).
  - Legality is decoded at the same time.
  - A legal request goes to ISSUE; an illegal one goes to RESP with the fault bit set.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal funct3 for stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 faults.
- Size is 1, 2 or 4 bytes. The range check `address + size - 1 <= DEPTH*4-1` is evaluated at ADDRESS_WIDTH+1 bits, so wrap-around counts as a fault.
- Misaligned in-range accesses are legal and are not split, because the cache is byte-addressed.
- ISSUE (exactly one cycle):
  - `mem.enable`=1, `mem.address`=registered address.
  - `mem.write_enable`=store flag.
  - `mem.byte_enable` = 0001 (byte), 0011 (half), 1111 (word); for loads the cache ignores it.
  - `mem.write_data`=registered store data, unshifted: byte i goes to address+i.
  - A store goes next to RESP; a load goes to CAPTURE.
- CAPTURE:
  - `mem.read_data` is valid.
  - `resp_data` is registered as follows: LB = sext(rd[7:0]), LBU = zext(rd[7:0]), LH = sext(rd[15:0]), LHU = zext(rd[15:0]), LW = rd.
  - Next state is RESP.
- RESP:
  - `resp_valid`=1, and `resp_data` and `resp_fault` are held stable.
  - On `resp_ready`, the unit returns to IDLE.
  - A new request cannot be accepted in the same cycle, because `req_ready`=0 outside IDLE.
- Outside ISSUE, `mem.enable`=0 and `mem.write_enable`=0.
- A faulting request never asserts `mem.enable`.

## Timing
- Latency is measured from the accept edge T (`req_valid` high in IDLE) to `resp_valid` high:
  - faulting request: 1 cycle;
  - store: 2 cycles, with `mem.enable` during cycle T..T+1;
  - load: 3 cycles.
- Throughput: one request per (latency + 1) cycles when `resp_ready` is held high.
- Backpressure: `resp_valid`, `resp_data` and `resp_fault` hold for any number of cycles while `resp_ready`=0. No memory activity occurs during this time.
- Reset values:
  - state IDLE, `req_ready`=1;
  - `resp_valid`=0, `resp_data`=0, `resp_fault`=0;
  - `mem.enable`=0, `mem.write_enable`=0, `mem.byte_enable`=0, `mem.address`=0, `mem.write_data`=0.
- Reset mid-operation: the transaction is abandoned. Memory strobes deassert immediately (asynchronous), no response is produced, and the unit resumes in IDLE.
- `resp_ready` high outside RESP is ignored.

## Test plan
- Word store/load: SW 0xDEADBEEF at 0x8, then LW 0x8.
  - The store response arrives 2 cycles after accept, with byte_enable=1111.
  - The load gives resp_data=0xDEADBEEF 3 cycles after accept, with exactly one enable pulse.
- Sub-word loads after the word store:
  - LB 0x8 gives 0xFFFFFFEF; LBU 0x8 gives 0x000000EF.
  - LH 0xA gives 0xFFFFDEAD; LHU 0xA gives 0x0000DEAD.
- Byte store: SB 0x55 at 0x9 drives address 0x9 and byte_enable 0001. A following LW 0x8 gives 0xDEAD55EF.
- Misaligned access: SW 0x11223344 at 0xC, then LW 0xA, gives 0x3344DEAD. LH 0x3E with DEPTH=16 returns normally.
- Faults (DEPTH=16):
  - LW 0x3E gives resp_fault=1, resp_data=0, 1-cycle latency, and mem.enable never high.
  - LW 0xFFFFFFFE gives a fault (wrap-around).
  - Load funct3 011 and store funct3 100 both give a fault.
- Backpressure and reset:
  - With resp_ready low for 5 cycles, the response holds, req_ready stays 0, and no extra enable occurs.
  - Asserting reset_n low during ISSUE drops enable at once, leaves resp_valid=0, and req_ready=1 after reset is released.
